// File: rtl/muldiv_pkg.sv
// Shared op codes, sequencer states and engine cycle counts
// for the HI/LO sequencer and the mult/div engines.
package muldiv_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT_RUN,
    S_DIV_RUN,
    S_WRITE
  } state_t;

  localparam int MULT_CYCLES_DEF = 32;
  localparam int DIV_CYCLES_DEF  = 32;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hilo_regfile.sv
// Architectural HI/LO register pair with independent
// write enables and synchronous reset.
module hilo_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] hi_d,
  input  logic [DATA_W-1:0] lo_d,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO sequencer between control unit and mult/div engines.
// Define HILO_ABORT_EN to add the abort input for cancelling a run.
module hilo_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
`ifdef HILO_ABORT_EN
  input  logic              abort,
`endif
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              busy,
  output logic              div_zero,
  output logic              mult_start,
  output logic [DATA_W-1:0] mult_a,
  output logic [DATA_W-1:0] mult_b,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  output logic              div_start,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  input  logic [DATA_W-1:0] div_quot,
  input  logic [DATA_W-1:0] div_rem,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W =
    $clog2(max2(MULT_CYCLES, DIV_CYCLES) + 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               busy_n, is_div, is_div_n;
  logic               ms_n, ds_n, dz_n;
  logic               ld_mult, ld_div;
  logic               hi_we, lo_we;
  logic [DATA_W-1:0]  hi_d, lo_d;
  logic               kill;

`ifdef HILO_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    busy_n   = busy;
    is_div_n = is_div;
    ms_n     = 1'b0;
    ds_n     = 1'b0;
    dz_n     = 1'b0;
    ld_mult  = 1'b0;
    ld_div   = 1'b0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_d     = rs_data;
    lo_d     = rs_data;
    unique case (state)
      S_IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_MULT: begin
              state_n  = S_MULT_RUN;
              cnt_n    = '0;
              busy_n   = 1'b1;
              ms_n     = 1'b1;
              ld_mult  = 1'b1;
              is_div_n = 1'b0;
            end
            OP_DIV: begin
              // zero divisor never reaches the engine
              if (rt_data == '0) begin
                dz_n = 1'b1;
              end else begin
                state_n  = S_DIV_RUN;
                cnt_n    = '0;
                busy_n   = 1'b1;
                ds_n     = 1'b1;
                ld_div   = 1'b1;
                is_div_n = 1'b1;
              end
            end
            OP_MTHI: hi_we = 1'b1;
            OP_MTLO: lo_we = 1'b1;
            default: ;
          endcase
        end
      end
      S_MULT_RUN, S_DIV_RUN: begin
        cnt_n = cnt + CNT_W'(1);
        if (kill) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
        end else if (state == S_MULT_RUN
                     && cnt == CNT_W'(MULT_CYCLES)) begin
          state_n = S_WRITE;
        end else if (state == S_DIV_RUN
                     && cnt == CNT_W'(DIV_CYCLES)) begin
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        hi_we   = 1'b1;
        lo_we   = 1'b1;
        hi_d    = is_div ? div_rem  : mult_hi;
        lo_d    = is_div ? div_quot : mult_lo;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      is_div     <= 1'b0;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      div_zero   <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      div_a      <= '0;
      div_b      <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      busy       <= busy_n;
      is_div     <= is_div_n;
      mult_start <= ms_n;
      div_start  <= ds_n;
      div_zero   <= dz_n;
      if (ld_mult) begin
        mult_a <= rs_data;
        mult_b <= rt_data;
      end
      if (ld_div) begin
        div_a <= rs_data;
        div_b <= rt_data;
      end
    end
  end

  hilo_regfile #(
    .DATA_W(DATA_W)
  ) u_regs (
    .clock(clock),
    .reset(reset),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .hi_d (hi_d),
    .lo_d (lo_d),
    .hi   (hi),
    .lo   (lo)
  );

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: table of ops with a result scoreboard,
// plus hand sequences for reset, back-to-back, ignore and abort.
module tb_hilo_unit;

  localparam int W = 32;
  localparam int N = 32;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         op_valid;
  logic [2:0]   op_code;
  logic [W-1:0] rs_data, rt_data;
  logic         busy, div_zero, mult_start, div_start;
  logic [W-1:0] mult_a, mult_b, mult_hi, mult_lo;
  logic [W-1:0] div_a, div_b, div_quot, div_rem;
  logic [W-1:0] hi, lo;
`ifdef HILO_ABORT_EN
  logic         abort;
`endif

  int   checks = 0;
  int   errors = 0;
  int   ms_n = 0, ds_n = 0, dz_n = 0;
  exp_t q[$];
  vec_t vecs[10];

  always #5 clock = ~clock;

  hilo_unit dut (
    .clock     (clock),
    .reset     (reset),
`ifdef HILO_ABORT_EN
    .abort     (abort),
`endif
    .op_valid  (op_valid),
    .op_code   (op_code),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .busy      (busy),
    .div_zero  (div_zero),
    .mult_start(mult_start),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_hi   (mult_hi),
    .mult_lo   (mult_lo),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_quot  (div_quot),
    .div_rem   (div_rem),
    .hi        (hi),
    .lo        (lo)
  );

  // engine models: garbage until N cycles after the start pulse
  logic signed [63:0] m_res;
  int                 m_cnt;
  logic               m_run;
  logic [W-1:0]       d_q, d_r;
  int                 d_cnt;
  logic               d_run;

  always @(posedge clock) begin
    if (reset) begin
      m_run <= 1'b0;
      m_cnt <= 0;
    end else if (mult_start) begin
      m_res <= $signed({{32{mult_a[31]}}, mult_a})
             * $signed({{32{mult_b[31]}}, mult_b});
      m_cnt <= 0;
      m_run <= 1'b1;
    end else if (m_run && m_cnt < N) begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      d_run <= 1'b0;
      d_cnt <= 0;
    end else if (div_start) begin
      d_q   <= W'($signed(div_a) / $signed(div_b));
      d_r   <= W'($signed(div_a) % $signed(div_b));
      d_cnt <= 0;
      d_run <= 1'b1;
    end else if (d_run && d_cnt < N) begin
      d_cnt <= d_cnt + 1;
    end
  end

  assign mult_hi  = (m_run && m_cnt >= N) ? m_res[63:32] : 32'hBAD0BAD0;
  assign mult_lo  = (m_run && m_cnt >= N) ? m_res[31:0]  : 32'hBAD1BAD1;
  assign div_quot = (d_run && d_cnt >= N) ? d_q : 32'hBAD2BAD2;
  assign div_rem  = (d_run && d_cnt >= N) ? d_r : 32'hBAD3BAD3;

  always @(negedge clock) begin
    if (mult_start) ms_n++;
    if (div_start)  ds_n++;
    if (div_zero)   dz_n++;
  end

  task automatic check(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] rs,
                       input logic [W-1:0] rt);
    @(negedge clock);
    op_valid = 1'b1;
    op_code  = op;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  task automatic do_op(input vec_t v, input int idx);
    exp_t e;
    int   cyc;
    bit   is_m, is_d, is_z;
    is_m = (v.op == 3'b001);
    is_d = (v.op == 3'b010) && (v.rt != 0);
    is_z = (v.op == 3'b010) && (v.rt == 0);
    drive(v.op, v.rs, v.rt);
    q.push_back('{v.hi, v.lo});
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    op_code  = 3'b000;
    ms_n = 0;
    ds_n = 0;
    dz_n = 0;
    wait_idle(cyc);
    check($sformatf("v%0d latency", idx), W'(cyc), W'(v.lat));
    repeat (2) @(negedge clock);
    #1;
    check($sformatf("v%0d mult_start", idx), W'(ms_n), W'(is_m));
    check($sformatf("v%0d div_start", idx), W'(ds_n), W'(is_d));
    check($sformatf("v%0d div_zero", idx), W'(dz_n), W'(is_z));
    e = q.pop_front();
    check($sformatf("v%0d hi", idx), hi, e.hi);
    check($sformatf("v%0d lo", idx), lo, e.lo);
  endtask

  initial begin
    int   cyc;
    vec_t rv;
    vecs[0] = '{3'b001, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, 34};
    vecs[1] = '{3'b010, 32'd7, 32'd2, 32'h00000001, 32'h00000003, 34};
    vecs[2] = '{3'b010, 32'd100, 32'd0, 32'h00000001, 32'h00000003, 0};
    vecs[3] = '{3'b001, 32'h10000, 32'h10000, 32'h00000001, 32'h00000000, 34};
    vecs[4] = '{3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34};
    vecs[5] = '{3'b011, 32'hDEADBEEF, 32'd9, 32'hDEADBEEF, 32'hFFFFFFFD, 0};
    vecs[6] = '{3'b100, 32'h12345678, 32'd9, 32'hDEADBEEF, 32'h12345678, 0};
    vecs[7] = '{3'b111, 32'h5, 32'h6, 32'hDEADBEEF, 32'h12345678, 0};
    vecs[8] = '{3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 34};
    vecs[9] = '{3'b010, 32'h80000000, 32'h10, 32'h00000000, 32'hF8000000, 34};

    reset    = 1'b1;
    op_valid = 1'b0;
    op_code  = 3'b000;
    rs_data  = '0;
    rt_data  = '0;
`ifdef HILO_ABORT_EN
    abort    = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    check("rst busy", W'(busy), 0);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    check("rst mult_start", W'(mult_start), 0);
    check("rst div_start", W'(div_start), 0);
    check("rst div_zero", W'(div_zero), 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) do_op(vecs[i], i);

    // MTHI then MTLO on consecutive cycles
    drive(3'b011, 32'hCAFEF00D, 32'd0);
    @(posedge clock);
    #1;
    check("b2b hi", hi, 32'hCAFEF00D);
    @(negedge clock);
    op_code = 3'b100;
    rs_data = 32'hA5A5A5A5;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    check("b2b lo", lo, 32'hA5A5A5A5);
    check("b2b hi kept", hi, 32'hCAFEF00D);

    // ops presented during a MULT run are ignored
    drive(3'b001, 32'd2, 32'd3);
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    dz_n = 0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    op_valid = 1'b1;
    op_code  = 3'b011;
    rs_data  = 32'h1111;
    @(posedge clock);
    #1;
    op_code  = 3'b010;
    rs_data  = 32'd9;
    rt_data  = 32'd0;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    wait_idle(cyc);
    check("ign busy low", W'(busy), 0);
    check("ign hi", hi, 32'h00000000);
    check("ign lo", lo, 32'h00000006);
    check("ign div_zero", W'(dz_n), 0);
    // accepted in the first cycle busy is low
    drive(3'b100, 32'h77, 32'd0);
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    check("next op lo", lo, 32'h77);

    // reset in the middle of a MULT run
    drive(3'b001, 32'd5, 32'd5);
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("mid rst busy", W'(busy), 0);
    check("mid rst hi", hi, 0);
    check("mid rst lo", lo, 0);
    check("mid rst mult_start", W'(mult_start), 0);
    check("mid rst div_start", W'(div_start), 0);
    @(negedge clock);
    reset = 1'b0;
    rv = '{3'b001, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1, 34};
    do_op(rv, 10);

`ifdef HILO_ABORT_EN
    drive(3'b001, 32'd4, 32'd4);
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    check("abort busy", W'(busy), 0);
    repeat (40) @(posedge clock);
    #1;
    check("abort hi", hi, 32'hFFFFFFFF);
    check("abort lo", lo, 32'hFFFFFFF1);
    check("abort busy later", W'(busy), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
